// File: rtl/gate_bank_tester.sv
// Self-test sequencer for the 8-output two-input gate bank: walks {a,b} through
// 00..11, settles, samples the bank result and accumulates mismatch results.
module gate_bank_tester #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic       drive_a_o,
    output logic       drive_b_o,
    input  logic [7:0] observe_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] fail_mask_o,
    output logic [3:0] fail_vec_o,
    output logic [2:0] err_count_o
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned RES_W   = 8;
    localparam int unsigned COMBO_W = 2;
    localparam int unsigned NCOMBO  = 4;
    localparam int unsigned ERR_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [COMBO_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [COMBO_W-1:0]   drive_q, drive_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [RES_W-1:0]     mask_q, mask_d;
    logic [NCOMBO-1:0]    vec_q, vec_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [RES_W-1:0]     mism;

    // Golden truth-table row for combination {a,b}
    function automatic logic [RES_W-1:0] golden(input logic [COMBO_W-1:0] combo);
        logic [RES_W-1:0] v;
        case (combo)
            2'b00:   v = 8'h78;
            2'b01:   v = 8'h1E;
            2'b10:   v = 8'h96;
            default: v = 8'hC3;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            drive_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            vec_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            drive_q <= drive_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        mask_d  = mask_q;
        vec_d   = vec_q;
        err_d   = err_q;
        done_d  = 1'b0;
        mism    = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pass_d  = 1'b0;
                    mask_d  = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    idx_d   = '0;
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                mism   = observe_i ^ golden(idx_q);
                mask_d = mask_q | mism;
                if (mism != '0) begin
                    vec_d[idx_q] = 1'b1;
                    err_d        = err_q + ERR_W'(1);
                end
                // Results become visible in the FINISH cycle, so pass uses the updated count
                if (idx_q == COMBO_W'(NCOMBO - 1)) begin
                    pass_d  = (err_d == '0);
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + COMBO_W'(1);
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = DRIVE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == DRIVE) || (state_d == SAMPLE);
        drive_d = busy_d ? idx_d : '0;
    end

    assign drive_a_o   = drive_q[1];
    assign drive_b_o   = drive_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_mask_o = mask_q;
    assign fail_vec_o  = vec_q;
    assign err_count_o = err_q;

endmodule
